// File: rtl/udp_rx_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udp_rx_stream_reader_pkg
// Description : Shared constants and types for the UDP receive stream reader.
// Revision    : 1.0
// ============================================================================
package udp_rx_stream_reader_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    DRAIN = ST_DRAIN
  } state_t;

  localparam int HDR_LEN_DEF = 8;
  localparam int RAM_RD_LAT  = 1;
  // Skid entry: {last, data[7:0]}
  localparam int SKID_W      = 9;

endpackage
`default_nettype wire

// File: rtl/udp_rd_skid.sv
`default_nettype none
// ============================================================================
// Module      : udp_rd_skid
// Description : Two-entry FIFO absorbing RAM read data while the sink stalls.
// Revision    : 1.0
// ============================================================================
module udp_rd_skid
  import udp_rx_stream_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [SKID_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [1:0]        count_o,
  output logic              valid_o,
  output logic [SKID_W-1:0] data_o
);

  logic [SKID_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o = count_q;
  assign valid_o = (count_q != 2'd0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire

// File: rtl/udp_rx_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : udp_rx_stream_reader
// Description : Streams a received UDP payload out of the receive RAM.
//               Optional drop counter enabled by UDP_RX_RD_DROP_CNT_EN.
// Revision    : 1.0
// ============================================================================
module udp_rx_stream_reader
  import udp_rx_stream_reader_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int HDR_LEN = HDR_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              udp_rec_data_valid,
  input  logic [15:0]       udp_rec_data_length,
  output logic [ADDR_W-1:0] udp_rec_ram_read_addr,
  input  logic [7:0]        udp_rec_ram_rdata,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [15:0]       m_len,
  output logic              busy,
  output logic              overrun
`ifdef UDP_RX_RD_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam logic [15:0] c_depth = 16'(32'd1 << ADDR_W);
  localparam logic [15:0] c_hdr   = 16'(HDR_LEN);

  state_t                state_q;
  logic                  valid_q;
  logic                  valid_qq;
  logic [15:0]           m_len_q;
  logic [ADDR_W:0]       rd_cnt_q;
  logic [ADDR_W:0]       rd_cnt_d;
  logic [RAM_RD_LAT-1:0] rv_q;
  logic [RAM_RD_LAT-1:0] rl_q;
  logic                  busy_q;
  logic                  overrun_q;

  logic                  w_rise;
  logic                  w_fall;
  logic                  w_len_ok;
  logic [15:0]           w_pay;
  logic [15:0]           w_len;
  logic                  w_pop;
  logic [1:0]            w_cnt;
  logic [2:0]            w_occ;
  logic                  w_room;
  logic                  w_issue;
  logic                  w_last_rd;
  logic                  w_sk_valid;
  logic [SKID_W-1:0]     w_sk_data;

  // Edge detection runs on the registered copy, giving the fixed 3-cycle latency.
  assign w_rise   = valid_q & ~valid_qq;
  assign w_fall   = ~valid_q & valid_qq;
  assign w_len_ok = (udp_rec_data_length > c_hdr);
  assign w_pay    = udp_rec_data_length - c_hdr;
  assign w_len    = (w_pay > c_depth) ? c_depth : w_pay;

  // Occupancy counts the entry leaving this cycle so a steady stream has no bubbles.
  assign w_pop     = w_sk_valid & m_ready;
  assign w_occ     = {1'b0, w_cnt} + 3'($countones(rv_q)) - {2'b00, w_pop};
  assign w_room    = (w_occ < 3'd2);
  assign w_issue   = (state_q == READ) && (16'(rd_cnt_q) != m_len_q) && w_room;
  assign w_last_rd = (16'(rd_cnt_q) == (m_len_q - 16'd1));
  assign rd_cnt_d  = rd_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      valid_qq  <= 1'b0;
      m_len_q   <= '0;
      rd_cnt_q  <= '0;
      rv_q      <= '0;
      rl_q      <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= udp_rec_data_valid;
      valid_qq  <= valid_q;
      overrun_q <= w_fall & busy_q;
      rv_q[0]   <= w_issue;
      rl_q[0]   <= w_issue & w_last_rd;
      for (int i = 1; i < RAM_RD_LAT; i++) begin
        rv_q[i] <= rv_q[i-1];
        rl_q[i] <= rl_q[i-1];
      end
      case (state_q)
        IDLE: begin
          if (w_rise && w_len_ok) begin
            state_q  <= READ;
            m_len_q  <= w_len;
            rd_cnt_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        READ: begin
          if (w_issue) begin
            rd_cnt_q <= rd_cnt_d;
            if (16'(rd_cnt_d) == m_len_q) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_pop && m_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  udp_rd_skid u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rv_q[RAM_RD_LAT-1]),
    .push_data_i ({rl_q[RAM_RD_LAT-1], udp_rec_ram_rdata}),
    .pop_i       (w_pop),
    .count_o     (w_cnt),
    .valid_o     (w_sk_valid),
    .data_o      (w_sk_data)
  );

  assign udp_rec_ram_read_addr = (state_q == READ) ? rd_cnt_q[ADDR_W-1:0] : '0;
  assign m_valid = w_sk_valid;
  assign m_data  = w_sk_data[7:0];
  assign m_last  = w_sk_data[8];
  assign m_len   = m_len_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

`ifdef UDP_RX_RD_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (busy_q && (w_rise || w_fall) && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_udp_rx_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_udp_rx_stream_reader
// Description : Directed self-checking bench for udp_rx_stream_reader.
// Revision    : 1.0
// ============================================================================
module tb_udp_rx_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        udp_rec_data_valid;
  logic [15:0] udp_rec_data_length;
  logic [10:0] udp_rec_ram_read_addr;
  logic [7:0]  udp_rec_ram_rdata = 8'h00;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [15:0] m_len;
  logic        busy;
  logic        overrun;
`ifdef UDP_RX_RD_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int ma;
  int n_ovr;
  logic [7:0] ram [2048];

  always #5 clk = ~clk;

  always @(posedge clk) udp_rec_ram_rdata <= ram[udp_rec_ram_read_addr];

  udp_rx_stream_reader #(.ADDR_W(11), .HDR_LEN(8)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .udp_rec_data_valid    (udp_rec_data_valid),
    .udp_rec_data_length   (udp_rec_data_length),
    .udp_rec_ram_read_addr (udp_rec_ram_read_addr),
    .udp_rec_ram_rdata     (udp_rec_ram_rdata),
    .m_data                (m_data),
    .m_valid               (m_valid),
    .m_ready               (m_ready),
    .m_last                (m_last),
    .m_len                 (m_len),
    .busy                  (busy),
    .overrun               (overrun)
`ifdef UDP_RX_RD_DROP_CNT_EN
    ,
    .drop_cnt              (drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [15:0] len, input logic rdy);
    @(negedge clk);
    udp_rec_data_length = len;
    udp_rec_data_valid  = 1'b1;
    m_ready             = rdy;
  endtask

  task automatic lat_pre();
    repeat (3) begin
      @(negedge clk);
      chk("lat_pre_valid", 32'(m_valid), 32'd0);
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    udp_rec_data_valid = 1'b0;
    m_ready            = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_addr", 32'(udp_rec_ram_read_addr), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  // Accepts bytes until stop_n are taken; expects ram[0..] in order, last on exp_n-1.
  task automatic collect(input int exp_n, input int stop_n, input bit rnd,
                         input bit first_chk, output int max_addr);
    int         got = 0;
    int         cyc = 0;
    bit         pv  = 1'b0;
    bit         pr  = 1'b0;
    bit         r;
    logic [8:0] pdl = '0;
    max_addr = 0;
    while (got < stop_n && cyc < exp_n * 8 + 40) begin
      @(negedge clk);
      cyc++;
      if (first_chk && cyc == 1) chk("first_valid", 32'(m_valid), 32'd1);
      if (pv && !pr) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'({m_last, m_data}), 32'(pdl));
      end
      if (!rnd && got > 0) chk("no_bubble", 32'(m_valid), 32'd1);
      r = rnd ? ((cyc % 2 == 1) && ($urandom_range(0, 3) != 0)) : 1'b1;
      m_ready = r;
      if (m_valid && r) begin
        chk("byte", 32'({m_last, m_data}), 32'({(got == exp_n - 1), ram[got]}));
        got++;
      end
      pv  = m_valid;
      pr  = r;
      pdl = {m_last, m_data};
      if (32'(udp_rec_ram_read_addr) > max_addr) max_addr = 32'(udp_rec_ram_read_addr);
    end
    chk("byte_count", 32'(got), 32'(stop_n));
    if (stop_n == exp_n) begin
      @(negedge clk);
      chk("done_valid", 32'(m_valid), 32'd0);
      chk("done_busy", 32'(busy), 32'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_last"}, 32'(m_last), 32'd0);
    chk({tag, "_data"}, 32'(m_data), 32'd0);
    chk({tag, "_len"}, 32'(m_len), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_addr"}, 32'(udp_rec_ram_read_addr), 32'd0);
`ifdef UDP_RX_RD_DROP_CNT_EN
    chk({tag, "_drop"}, 32'(drop_cnt), 32'd0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 8'((i * 29 + 7) ^ (i >> 3));
    rst                 = 1'b1;
    udp_rec_data_valid  = 1'b0;
    udp_rec_data_length = 16'd0;
    m_ready             = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;

    // Length 16: eight bytes, 3-cycle latency, back-to-back
    start(16'd16, 1'b1);
    lat_pre();
    chk("t16_busy", 32'(busy), 32'd1);
    chk("t16_mlen", 32'(m_len), 32'd8);
    collect(8, 8, 1'b0, 1'b1, ma);
    end_frame();

    // Length 9: single byte carrying last
    start(16'd9, 1'b1);
    lat_pre();
    chk("t9_mlen", 32'(m_len), 32'd1);
    collect(1, 1, 1'b0, 1'b1, ma);
    end_frame();

    // Length 8: header only, ignored
    start(16'd8, 1'b1);
    repeat (6) begin
      @(negedge clk);
      chk("t8_busy", 32'(busy), 32'd0);
      chk("t8_valid", 32'(m_valid), 32'd0);
    end
    end_frame();

    // Length 108 under toggling/random backpressure
    start(16'd108, 1'b0);
    lat_pre();
    chk("t108_mlen", 32'(m_len), 32'd100);
    collect(100, 100, 1'b1, 1'b1, ma);
    end_frame();

    // Overrun: valid falls then rises mid-readout
    start(16'd40, 1'b0);
    lat_pre();
    repeat (3) @(negedge clk);
    @(negedge clk);
    udp_rec_data_valid = 1'b0;
    n_ovr = 0;
    repeat (5) begin
      @(negedge clk);
      if (overrun) n_ovr++;
    end
    chk("ovr_pulses", 32'(n_ovr), 32'd1);
    udp_rec_data_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("ovr_busy", 32'(busy), 32'd1);
    chk("ovr_mlen", 32'(m_len), 32'd32);
    chk("ovr_low", 32'(overrun), 32'd0);
    collect(32, 32, 1'b1, 1'b0, ma);
`ifdef UDP_RX_RD_DROP_CNT_EN
    chk("ovr_drop_cnt", 32'(drop_cnt), 32'd2);
`endif
    end_frame();

    // Length 3000: clamped to RAM depth
    start(16'd3000, 1'b1);
    lat_pre();
    chk("clamp_mlen", 32'(m_len), 32'd2048);
    collect(2048, 2048, 1'b0, 1'b1, ma);
    chk("clamp_max_addr", 32'(ma), 32'd2047);
    end_frame();

    // Reset at byte 5 of 50, then restart with valid still high
    start(16'd58, 1'b1);
    lat_pre();
    collect(50, 5, 1'b0, 1'b1, ma);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lat_pre();
    chk("restart_mlen", 32'(m_len), 32'd50);
    collect(50, 50, 1'b0, 1'b1, ma);
    end_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
